// File: rtl/tlk2711_pkg.sv
// Shared constants and types for the multi-lane TLK2711 transmit frame generator.
package tlk2711_pkg;

    localparam logic [15:0] K_IDLE = 16'hBCC5;  // K28.5 / D5.6
    localparam logic [15:0] K_SOF  = 16'hFB50;
    localparam logic [15:0] K_EOF  = 16'hFD50;

    localparam logic [1:0] MODE_COUNTER = 2'd0;
    localparam logic [1:0] MODE_PRBS    = 2'd1;
    localparam logic [1:0] MODE_FIXED   = 2'd2;
    localparam logic [1:0] MODE_WALK    = 2'd3;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_SOF  = 3'd1;
    localparam logic [2:0] ST_HDR  = 3'd2;
    localparam logic [2:0] ST_PAY  = 3'd3;
    localparam logic [2:0] ST_EOF  = 3'd4;
    localparam logic [2:0] ST_GAP  = 3'd5;

    // x^15 + x^14 + 1: feedback taps on the two oldest state bits
    localparam logic [14:0] PRBS_POLY      = 15'h6000;
    localparam logic [14:0] PRBS_SEED_BASE = 15'h7FFF;

    typedef struct packed {
        logic [15:0] data;
        logic        kmsb;
        logic        klsb;
    } lane_word_t;

    function automatic logic [14:0] prbs15_step(input logic [14:0] s);
        return {s[13:0], ^(s & PRBS_POLY)};
    endfunction

endpackage

// File: rtl/prbs15_word_gen.sv
// PRBS-15 generator producing 16 sequence bits per word, earliest bit in the MSB.
module prbs15_word_gen
    import tlk2711_pkg::*;
(
    input  logic        tx_clk,
    input  logic        rst,
    input  logic        load,
    input  logic        advance,
    input  logic [14:0] seed,
    output logic [15:0] word
);

    logic [14:0] lfsr_reg;
    logic [14:0] lfsr_next;
    logic [14:0] walk;

    always_comb begin
        walk = lfsr_reg;
        word = '0;
        for (int i = 0; i < 16; i++) begin
            walk = prbs15_step(walk);
            word = {word[14:0], walk[0]};
        end
        lfsr_next = walk;
    end

    always_ff @(posedge tx_clk) begin
        if (rst) begin
            lfsr_reg <= PRBS_SEED_BASE;
        end else if (load) begin
            lfsr_reg <= seed;
        end else if (advance) begin
            lfsr_reg <= lfsr_next;
        end
    end

endmodule

// File: rtl/tlk2711_tx_gen.sv
// Framed multi-lane TLK2711 transmit generator: SOF, header, payload, EOF, idle gap.
module tlk2711_tx_gen
    import tlk2711_pkg::*;
#(
    parameter int NUM_CH    = 2,
    parameter int FRAME_LEN = 256,
    parameter int IDLE_GAP  = 4
) (
    input  logic                 tx_clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic                 i_stop,
    input  logic [1:0]           i_mode,
    input  logic [15:0]          i_pattern,
    output logic                 o_stop_ack,
    output logic                 o_busy,
    output logic [11:0]          o_frame_cnt,
    output logic [16*NUM_CH-1:0] o_txd,
    output logic [NUM_CH-1:0]    o_tkmsb,
    output logic [NUM_CH-1:0]    o_tklsb,
    output logic                 o_loopen,
    output logic                 o_prbsen,
    output logic                 o_testen,
    output logic                 o_enable,
    output logic                 o_lckrefn
);

    localparam logic [15:0] PAY_LAST = 16'(FRAME_LEN - 1);
    localparam logic [15:0] GAP_LAST = 16'(IDLE_GAP - 1);

    logic [2:0]  state_reg, state_next;
    logic [15:0] cnt_reg, cnt_next;
    logic        stop_flag_reg, stop_flag_next;
    logic        ack_pend_reg, ack_pend_next;
    logic [1:0]  mode_reg, mode_next;
    logic [15:0] pattern_reg, pattern_next;
    logic [11:0] frame_cnt_reg, frame_cnt_next;

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        stop_flag_next = stop_flag_reg;
        ack_pend_next  = 1'b0;
        mode_next      = mode_reg;
        pattern_next   = pattern_reg;
        frame_cnt_next = frame_cnt_reg;

        if (state_reg != ST_IDLE && i_stop) begin
            stop_flag_next = 1'b1;
        end

        case (state_reg)
            ST_IDLE: begin
                // Stop has priority over a simultaneous start
                if (i_stop) begin
                    ack_pend_next = 1'b1;
                end else if (i_start) begin
                    state_next   = ST_SOF;
                    mode_next    = i_mode;
                    pattern_next = i_pattern;
                end
            end
            ST_SOF: state_next = ST_HDR;
            ST_HDR: begin
                state_next = ST_PAY;
                cnt_next   = '0;
            end
            ST_PAY: begin
                if (cnt_reg == PAY_LAST) begin
                    state_next     = ST_EOF;
                    frame_cnt_next = frame_cnt_reg + 12'd1;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            ST_EOF: begin
                state_next = ST_GAP;
                cnt_next   = '0;
            end
            ST_GAP: begin
                if (cnt_reg == GAP_LAST) begin
                    if (stop_flag_reg || i_stop) begin
                        state_next     = ST_IDLE;
                        ack_pend_next  = 1'b1;
                        stop_flag_next = 1'b0;
                    end else begin
                        state_next   = ST_SOF;
                        mode_next    = i_mode;
                        pattern_next = i_pattern;
                    end
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Control state plus the registered status outputs, which lag state by one cycle
    always_ff @(posedge tx_clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            stop_flag_reg <= 1'b0;
            ack_pend_reg  <= 1'b0;
            mode_reg      <= MODE_COUNTER;
            pattern_reg   <= '0;
            frame_cnt_reg <= '0;
            o_busy        <= 1'b0;
            o_stop_ack    <= 1'b0;
            o_frame_cnt   <= '0;
            o_enable      <= 1'b0;
            o_lckrefn     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            stop_flag_reg <= stop_flag_next;
            ack_pend_reg  <= ack_pend_next;
            mode_reg      <= mode_next;
            pattern_reg   <= pattern_next;
            frame_cnt_reg <= frame_cnt_next;
            o_busy        <= (state_reg != ST_IDLE);
            o_stop_ack    <= ack_pend_reg;
            o_frame_cnt   <= frame_cnt_reg;
            o_enable      <= 1'b1;
            o_lckrefn     <= 1'b1;
        end
    end

    assign o_loopen = 1'b0;
    assign o_prbsen = 1'b0;
    assign o_testen = 1'b0;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lane
        logic [15:0] prbs_word;
        lane_word_t  lane_next;
        lane_word_t  lane_reg;

        prbs15_word_gen u_prbs (
            .tx_clk  (tx_clk),
            .rst     (rst),
            .load    (state_reg == ST_SOF),
            .advance (state_reg == ST_PAY),
            .seed    (PRBS_SEED_BASE ^ 15'(gi)),
            .word    (prbs_word)
        );

        always_comb begin
            lane_next = '{data: K_IDLE, kmsb: 1'b1, klsb: 1'b0};
            case (state_reg)
                ST_SOF: lane_next.data = K_SOF;
                ST_EOF: lane_next.data = K_EOF;
                ST_HDR: lane_next = '{data: {4'(gi), frame_cnt_reg}, kmsb: 1'b0, klsb: 1'b0};
                ST_PAY: begin
                    lane_next.kmsb = 1'b0;
                    case (mode_reg)
                        MODE_COUNTER: lane_next.data = cnt_reg;
                        MODE_PRBS:    lane_next.data = prbs_word;
                        MODE_FIXED:   lane_next.data = pattern_reg;
                        default:      lane_next.data = 16'h0001 << cnt_reg[3:0];
                    endcase
                end
                default: ;
            endcase
        end

        always_ff @(posedge tx_clk) begin
            if (rst) begin
                lane_reg <= '{data: K_IDLE, kmsb: 1'b1, klsb: 1'b0};
            end else begin
                lane_reg <= lane_next;
            end
        end

        assign o_txd[16*gi +: 16] = lane_reg.data;
        assign o_tkmsb[gi]        = lane_reg.kmsb;
        assign o_tklsb[gi]        = lane_reg.klsb;
    end

endmodule
